tick_scheduler: RTL

//   Shared timebase scheduler for the 50 MHz system clock.
//   - Divides clk by CLK_DIV into a one-cycle base_tick strobe (1 us at defaults).
//   - Runs NCH independent channel timers off that strobe, each periodic or one-shot.
//   - Emits one-cycle ch_fire enables, so consumers need no private divided clocks.

---
 rtl/tick_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared clk prescaler plus NCH periodic/one-shot
// channel timers that emit one-cycle fire enables off the base tick.
module tick_scheduler #(
  parameter int CLK_DIV = 50,
  parameter int NCH     = 4,
  parameter int PW      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 cfg_wr,
  input  logic [$clog2(NCH):0] cfg_ch,
  input  logic [PW-1:0]        cfg_period,
  input  logic                 cfg_oneshot,
  input  logic                 cfg_start,
  output logic                 base_tick,
  output logic [NCH-1:0]       ch_fire,
  output logic [NCH-1:0]       ch_active
);

  localparam int CW  = $clog2(NCH) + 1;
  localparam int PCW = $clog2(CLK_DIV);
  localparam logic [PCW-1:0] PRE_LAST = PCW'(CLK_DIV - 1);

  typedef enum logic {
    S_IDLE,
    S_ARMED
  } ch_state_t;

  logic [PCW-1:0] r_pre_cnt;
  logic           r_base_tick;
  logic           w_pre_wrap;
  logic           w_count;

  assign w_pre_wrap = (r_pre_cnt == PRE_LAST);
  assign w_count    = r_base_tick & run;
  assign base_tick  = r_base_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre_cnt   <= '0;
      r_base_tick <= 1'b0;
    end else if (!run) begin
      r_pre_cnt   <= '0;
      r_base_tick <= 1'b0;
    end else begin
      r_base_tick <= w_pre_wrap;
      r_pre_cnt   <= w_pre_wrap ? '0 : r_pre_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ch_state_t     r_state;
    ch_state_t     w_state_nxt;
    logic [PW-1:0] r_cnt;
    logic [PW-1:0] w_cnt_nxt;
    logic [PW-1:0] r_per;
    logic [PW-1:0] w_per_nxt;
    logic          r_os;
    logic          w_os_nxt;
    logic          r_fire;
    logic          w_fire_nxt;
    logic          w_wr;
    logic          w_step;

    // A config write to this channel pre-empts any tick in the same cycle.
    assign w_wr   = cfg_wr && (cfg_ch == CW'(g));
    assign w_step = w_count && (r_state == S_ARMED) && !w_wr;

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_per_nxt   = r_per;
      w_os_nxt    = r_os;
      w_fire_nxt  = 1'b0;
      unique case (1'b1)
        w_wr: begin
          w_per_nxt = cfg_period;
          w_os_nxt  = cfg_oneshot;
          if (cfg_start && (cfg_period != '0)) begin
            w_cnt_nxt   = cfg_period;
            w_state_nxt = S_ARMED;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        w_step: begin
          if (r_cnt > PW'(1)) begin
            w_cnt_nxt = r_cnt - PW'(1);
          end else begin
            w_fire_nxt = 1'b1;
            if (r_os) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = r_per;
            end
          end
        end
        default: begin
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_per   <= '0;
        r_os    <= 1'b0;
        r_fire  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_per   <= w_per_nxt;
        r_os    <= w_os_nxt;
        r_fire  <= w_fire_nxt;
      end
    end

    assign ch_fire[g]   = r_fire;
    assign ch_active[g] = (r_state == S_ARMED);
  end

endmodule
